// File: rtl/sram_rw_arbiter.sv
// rtl/sram_rw_arbiter.sv - round-robin two-requester arbiter with zero-fill sequencer for a single-port RW SRAM
module sram_rw_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512,
    parameter int DATA_W = 64,
    parameter int MASK_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear_req,
    output logic              init_busy,

    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_write,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    input  logic [MASK_W-1:0] a_req_wmask,
    output logic              a_resp_valid,
    output logic [DATA_W-1:0] a_resp_rdata,

    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_write,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_wdata,
    input  logic [MASK_W-1:0] b_req_wmask,
    output logic              b_resp_valid,
    output logic [DATA_W-1:0] b_resp_rdata,

    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [MASK_W-1:0] RW0_wmask,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] init_addr_q;
    logic              prio_b_q, prio_b_d;
    logic              a_pend_q, a_pend_d;
    logic              b_pend_q, b_pend_d;
    logic              run;
    logic              grant_a, grant_b;

    // prio_b_q names the requester that wins the next contended cycle (0 = A).
    always_comb begin
        run      = (state_q == ST_RUN);
        grant_a  = run & a_req_valid & (~b_req_valid | ~prio_b_q);
        grant_b  = run & b_req_valid & (~a_req_valid | prio_b_q);
        prio_b_d = prio_b_q;
        if (grant_a) begin
            prio_b_d = 1'b1;
        end else if (grant_b) begin
            prio_b_d = 1'b0;
        end
        a_pend_d = grant_a & ~a_req_write;
        b_pend_d = grant_b & ~b_req_write;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
            prio_b_q    <= 1'b0;
            a_pend_q    <= 1'b0;
            b_pend_q    <= 1'b0;
        end else begin
            prio_b_q <= prio_b_d;
            a_pend_q <= a_pend_d;
            b_pend_q <= b_pend_d;
            case (state_q)
                ST_INIT: begin
                    if (init_addr_q == LAST_ADDR) begin
                        state_q     <= ST_RUN;
                        init_addr_q <= '0;
                    end else begin
                        init_addr_q <= init_addr_q + ADDR_W'(1);
                    end
                end
                ST_RUN: begin
                    if (clear_req) begin
                        state_q     <= ST_INIT;
                        init_addr_q <= '0;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    // RW0_en is gated by reset_n so the macro stays idle while reset is held,
    // yet the first zero-fill write lands on the first edge after release.
    always_comb begin
        RW0_en    = 1'b0;
        RW0_wmode = 1'b0;
        RW0_addr  = a_req_addr;
        RW0_wdata = a_req_wdata;
        RW0_wmask = a_req_wmask;
        if (!run) begin
            RW0_en    = reset_n;
            RW0_wmode = 1'b1;
            RW0_addr  = init_addr_q;
            RW0_wdata = '0;
            RW0_wmask = '1;
        end else if (grant_b) begin
            RW0_en    = 1'b1;
            RW0_wmode = b_req_write;
            RW0_addr  = b_req_addr;
            RW0_wdata = b_req_wdata;
            RW0_wmask = b_req_wmask;
        end else if (grant_a) begin
            RW0_en    = 1'b1;
            RW0_wmode = a_req_write;
        end
    end

    assign init_busy    = (state_q == ST_INIT);
    assign a_req_ready  = grant_a;
    assign b_req_ready  = grant_b;
    assign a_resp_valid = a_pend_q;
    assign b_resp_valid = b_pend_q;
    assign a_resp_rdata = a_pend_q ? RW0_rdata : '0;
    assign b_resp_rdata = b_pend_q ? RW0_rdata : '0;

endmodule

// File: doc/sram_rw_arbiter.md
Name: sram_rw_arbiter

Overview:
- Shares one single-port RW SRAM macro (RW0_* interface, 1-cycle registered-address read latency, per-lane write mask) between two requesters, A and B.
- Arbitrates round-robin and returns read data with a fixed one-cycle response latency.
- Zero-fills the whole array after reset and on demand.
- Sits between a cache/queue pipeline and its *_ext SRAM macro; the macro clock is driven from the same clock.

Parameters:
- ADDR_W, 9, SRAM address width.
- DEPTH, 512, number of SRAM entries cleared by the init sequencer; at most 2**ADDR_W.
- DATA_W, 64, SRAM word width.
- MASK_W, 8, write-mask lanes; DATA_W divisible by MASK_W.

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear_req  in  1  pulse that requests a full zero-fill.
- init_busy  out  1  high while zero-filling.
- a_req_valid  in  1  requester A has a request.
- a_req_ready  out  1  A's request is accepted this cycle.
- a_req_write  in  1  1 = write, 0 = read.
- a_req_addr  in  ADDR_W  request address.
- a_req_wdata  in  DATA_W  write data.
- a_req_wmask  in  MASK_W  write lane enables.
- a_resp_valid  out  1  read data valid for A.
- a_resp_rdata  out  DATA_W  read data for A.
- b_*: identical set of eight request/response ports for requester B.
- RW0_addr  out  ADDR_W  to macro.
- RW0_en  out  1  to macro.
- RW0_wmode  out  1  to macro.
- RW0_wmask  out  MASK_W  to macro.
- RW0_wdata  out  DATA_W  to macro.
- RW0_rdata  in  DATA_W  from macro.

Behaviour:
- Reset (reset_n low, async):
  - State = INIT, init_addr = 0, priority pointer = A, pending-response registers cleared.
  - Outputs: init_busy=1, RW0_en=0, both ready=0, both resp_valid=0, both resp_rdata=0.
- States:
  - INIT: each cycle drives RW0_en=1, RW0_wmode=1, RW0_wmask=all ones, RW0_wdata=0, RW0_addr=init_addr; then init_addr increments. The first write occurs in the first clock edge after reset_n rises.
  - INIT → RUN: after the write to init_addr==DEPTH-1. init_busy falls in the same cycle RUN begins. INIT lasts exactly DEPTH cycles.
  - RUN: arbitration active. clear_req sampled high → INIT next cycle with init_addr=0.
  - clear_req is ignored while in INIT. Reset mid-INIT restarts from address 0.
- Arbitration (RUN only, combinational grant):
  - Only one valid requester → it is granted.
  - Both valid → the requester named by the priority pointer wins.
  - After any grant, the pointer moves to the non-granted requester. Strict alternation under continuous contention; no starvation.
  - x_req_ready = grant_x; ready is 0 whenever the block is in INIT.
  - Ready may depend on valid; valid must not depend on ready.
- SRAM drive on a grant: RW0_en=1, RW0_wmode=req_write, and RW0_addr/wdata/wmask come from the winner. No grant → RW0_en=0, other RW0_* outputs don't-care.
- Read response:
  - A granted read in cycle n gives x_resp_valid=1 in cycle n+1, with x_resp_rdata=RW0_rdata.
  - x_resp_rdata is forced to 0 when x_resp_valid=0.
  - There is no response backpressure. Writes produce no response.
- Ordering:
  - A write in cycle n followed by a read of the same address in cycle n+1 (either requester) returns the new data.
  - A read granted in the cycle clear_req is sampled still delivers its response in the next cycle (the first INIT cycle).
- Throughput: one SRAM access per cycle in RUN.

Test Plan:
- Reset release, DEPTH=512 → init_busy high for exactly 512 cycles; RW0 writes addresses 0..511 with data 0 and mask 0xFF; then A reads addr 37 → a_resp_valid one cycle later with data 0.
- A writes addr 5 data 0x1122334455667788 mask 0x0F, then reads addr 5 → a_resp_rdata = 0x0000000055667788.
- A and B both hold valid reads for 6 cycles, pointer at A after reset → grants A,B,A,B,A,B; each resp_valid pulses the cycle after its grant, and only the correct requester's resp_valid is asserted.
- B write addr 9 = 0xDEAD in cycle n, A read addr 9 in cycle n+1 → a_resp_rdata = 0xDEAD in cycle n+2.
- clear_req pulsed while A's read is granted in that cycle → A's response arrives in the next cycle; init_busy=1 for 512 cycles; a later read of any previously written address returns 0.
- reset_n dropped asynchronously mid-INIT (init_addr=200) → outputs return to reset values immediately; after release, INIT restarts at address 0 and lasts a full 512 cycles.
